drive_ramp_controller: RTL
==========================

Name: drive_ramp_controller

Overview:
- Sits between the mode/drive FSM and the two motor H-bridges.
- Converts the registered 4-bit drive_state command into per-wheel direction and PWM outputs.
- Applies slew-rate-limited duty ramping, and enforces a brake-to-zero plus dwell sequence before any wheel reverses direction.
- Honours the FSM's mode-change pulse as an immediate stop.

Parameters:
- PWM_BITS, 8: duty/PWM counter width.
- RAMP_DIV, 50000: clk_50 cycles per ramp tick (1 ms).
- STEP, 4: duty change per ramp tick.
- DWELL_TICKS, 100: ramp ticks held at duty 0 before a reversal.
- SLOW_DUTY, 80: |duty| for SLOW and REVERSE.
- MEDIUM_DUTY, 160: |duty| for MEDIUM.
- FAST_DUTY, 240: |duty| for FAST.
- TURN_DUTY, 120: |duty| for LEFT, RIGHT, LREVERSE, RREVERSE.
- HARD_DUTY, 200: |duty| for HARD_L, HARD_R.

Ports:
- clk_50  in  1  system clock.
- rst_n  in  1  async active-low reset.
- drive_state  in  4  drive command code from the mode FSM.
- mode_reset  in  1  1-cycle pulse on mode or CAM sub-state change.
- pwm_l, pwm_r  out  1  PWM drive, left/right wheel.
- dir_l, dir_r  out  1  wheel direction, 1=forward.
- duty_l, duty_r  out  PWM_BITS  current applied duty.
- busy  out  1  any wheel braking, dwelling, or duty≠target.

Behaviour:
- Reset (async assert, sync deassert via clk_50): duty 0, dir 1, wheel state RUN, prescaler 0, PWM counter 0, pwm 0, busy 0.
- Target table, signed (L, R):
  - STOP (0, 0)
  - LEFT (0, +TURN)
  - RIGHT (+TURN, 0)
  - SLOW (+SLOW, +SLOW)
  - MEDIUM (+MED, +MED)
  - FAST (+FAST, +FAST)
  - REVERSE (−SLOW, −SLOW)
  - LREVERSE (0, −TURN)
  - RREVERSE (−TURN, 0)
  - HARD_L (−HARD, +HARD)
  - HARD_R (+HARD, −HARD)
  - codes 11–15 → STOP.
- Target is decoded combinationally and sampled each cycle.
- Prescaler counts 0..RAMP_DIV−1 and emits a 1-cycle tick at RAMP_DIV−1.
- All duty/dwell updates occur only on tick cycles, except mode_reset.
- Per-wheel FSM:
  - RUN: if target magnitude 0 or target direction == dir, step duty toward target magnitude: +STEP saturating at target, or −STEP floored at target.
  - RUN, direction mismatch with duty==0: set dir on that tick, stay RUN, step up on the next tick.
  - RUN, direction mismatch with duty≠0: go to BRAKE.
  - BRAKE: duty −STEP per tick, floored at 0.
    - Target direction returns to dir → RUN, with no duty discontinuity.
    - Duty reaches 0 → DWELL, dwell counter = 0.
  - DWELL: duty held 0 and counter increments per tick. At counter == DWELL_TICKS−1 → load dir from the current target (dir unchanged if target is 0) and go to RUN. Target changes during DWELL do not abort it.
- mode_reset (top priority, any cycle, no tick needed): next edge forces duty 0 on both wheels, state DWELL, counter 0. Prescaler is not reset.
- PWM: free-running PWM_BITS counter; pwm = (counter < duty), registered, 1-cycle latency. Duty 0 → pwm constantly 0.
- Duty never exceeds its target magnitude. No arithmetic wrap: compute in PWM_BITS+1 bits and saturate.
- busy is combinational from registered state.

Decomposition:
- Shared package (drive_pkg) holds:
  - drive_states enum (4-bit codes 0–10 as used by the mode FSM)
  - wheel state enum {RUN, BRAKE, DWELL}
  - duty-table constants.
- Sub-module wheel_ramp (one per wheel): inputs are tick, mode_reset, target magnitude, target direction; outputs are duty, dir, state.
- The top level holds the prescaler, target decode, PWM counter and busy.

Test Plan (RAMP_DIV=4, STEP=4, DWELL_TICKS=3):
- Reset release, drive_state=STOP for 100 cycles → duty_l=duty_r=0, pwm 0, dir 1, busy 0.
- STOP→SLOW → both duties rise 4 per tick, reaching 80 after 20 ticks (80 cycles); busy drops on the following cycle; pwm high 80 of every 256 cycles.
- SLOW(80) settled → REVERSE:
  - BRAKE: 20 ticks down to 0, dir still 1.
  - DWELL: 3 ticks.
  - Then dir=0, ramp to 80 over 20 ticks.
  - pwm never high while dir changes.
- SLOW→REVERSE, then back to SLOW when duty=40 during BRAKE → RUN immediately; duty climbs 44, 48… to 80; dir stays 1.
- FAST steady, pulse mode_reset → duty 0 on the next edge (mid-prescaler), 3-tick dwell, then ramps toward current target.
- HARD_L from STOP → left dir 0, right dir 1 (both switched at duty 0, no dwell); both ramp to 200 in 50 ticks. drive_state=13 → both ramp to 0, dirs unchanged.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared types and default duty table for the drive ramp controller.
package drive_pkg;

    // Drive command codes as emitted by the mode FSM; codes 11..15 decode as STOP.
    typedef enum logic [3:0] {
        DS_STOP     = 4'd0,
        DS_LEFT     = 4'd1,
        DS_RIGHT    = 4'd2,
        DS_SLOW     = 4'd3,
        DS_MEDIUM   = 4'd4,
        DS_FAST     = 4'd5,
        DS_REVERSE  = 4'd6,
        DS_LREVERSE = 4'd7,
        DS_RREVERSE = 4'd8,
        DS_HARD_L   = 4'd9,
        DS_HARD_R   = 4'd10
    } drive_state_e;

    // Per-wheel ramp state.
    typedef enum logic [1:0] {
        WS_RUN   = 2'd0,
        WS_BRAKE = 2'd1,
        WS_DWELL = 2'd2
    } wheel_state_e;

    // Default duty magnitudes.
    localparam int unsigned SLOW_DUTY_DEF   = 80;
    localparam int unsigned MEDIUM_DUTY_DEF = 160;
    localparam int unsigned FAST_DUTY_DEF   = 240;
    localparam int unsigned TURN_DUTY_DEF   = 120;
    localparam int unsigned HARD_DUTY_DEF   = 200;

endpackage

// File: rtl/wheel_ramp.sv
// Single-wheel duty ramp with brake-to-zero and dwell before direction reversal.
module wheel_ramp
    import drive_pkg::*;
#(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned STEP        = 4,
    parameter int unsigned DWELL_TICKS = 100
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                mode_reset,
    input  logic [PWM_BITS-1:0] tgt_mag,
    input  logic                tgt_dir,
    output logic [PWM_BITS-1:0] duty,
    output logic                dir,
    output wheel_state_e        state
);

    localparam int unsigned       CW         = $clog2(DWELL_TICKS + 1);
    localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [PWM_BITS:0] STEP_W     = (PWM_BITS + 1)'(STEP);

    wheel_state_e        state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                dir_ok;
    logic [PWM_BITS:0]   duty_w, tgt_w, up_w, dn_w, brake_w;
    logic [PWM_BITS-1:0] toward;
    logic [PWM_BITS-1:0] brake_dn;

    // Step arithmetic, done one bit wider and saturated so nothing wraps.
    always_comb begin
        dir_ok  = (tgt_mag == '0) || (tgt_dir == dir_q);
        duty_w  = {1'b0, duty_q};
        tgt_w   = {1'b0, tgt_mag};
        up_w    = duty_w + STEP_W;
        dn_w    = (duty_w >= tgt_w + STEP_W) ? (duty_w - STEP_W) : tgt_w;
        brake_w = (duty_w >= STEP_W) ? (duty_w - STEP_W) : '0;
        if (duty_q < tgt_mag) begin
            toward = (up_w > tgt_w) ? tgt_mag : up_w[PWM_BITS-1:0];
        end else begin
            toward = dn_w[PWM_BITS-1:0];
        end
        brake_dn = brake_w[PWM_BITS-1:0];
    end

    // State, duty, direction and dwell counter registers.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WS_RUN;
            duty_q  <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decision: mode_reset overrides everything, otherwise move only on tick.
    always_comb begin
        state_d = state_q;
        if (mode_reset) begin
            state_d = WS_DWELL;
        end else if (tick) begin
            case (state_q)
                WS_RUN: begin
                    if (!dir_ok && (duty_q != '0)) state_d = WS_BRAKE;
                end
                WS_BRAKE: begin
                    if (dir_ok)                 state_d = WS_RUN;
                    else if (brake_dn == '0)    state_d = WS_DWELL;
                end
                WS_DWELL: begin
                    if (cnt_q == DWELL_LAST)    state_d = WS_RUN;
                end
                default: state_d = WS_RUN;
            endcase
        end
    end

    // Duty, direction and dwell-count updates for the current state.
    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        if (mode_reset) begin
            duty_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            case (state_q)
                WS_RUN: begin
                    if (dir_ok)              duty_d = toward;
                    else if (duty_q == '0)   dir_d  = tgt_dir;
                end
                WS_BRAKE: begin
                    // Returning to the old direction resumes from the present duty.
                    if (!dir_ok) begin
                        duty_d = brake_dn;
                        cnt_d  = '0;
                    end
                end
                WS_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        if (tgt_mag != '0) dir_d = tgt_dir;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign duty  = duty_q;
    assign dir   = dir_q;
    assign state = state_q;

endmodule

// File: rtl/drive_ramp_controller.sv
// Drive command to per-wheel direction/PWM with slew-limited ramping.
module drive_ramp_controller
    import drive_pkg::*;
#(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned STEP        = 4,
    parameter int unsigned DWELL_TICKS = 100,
    parameter int unsigned SLOW_DUTY   = SLOW_DUTY_DEF,
    parameter int unsigned MEDIUM_DUTY = MEDIUM_DUTY_DEF,
    parameter int unsigned FAST_DUTY   = FAST_DUTY_DEF,
    parameter int unsigned TURN_DUTY   = TURN_DUTY_DEF,
    parameter int unsigned HARD_DUTY   = HARD_DUTY_DEF
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic [3:0]          drive_state,
    input  logic                mode_reset,
    output logic                pwm_l,
    output logic                pwm_r,
    output logic                dir_l,
    output logic                dir_r,
    output logic [PWM_BITS-1:0] duty_l,
    output logic [PWM_BITS-1:0] duty_r,
    output logic                busy
);

    localparam int unsigned         PW     = $clog2(RAMP_DIV + 1);
    localparam logic [PW-1:0]       P_LAST = PW'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] SLOW_M = PWM_BITS'(SLOW_DUTY);
    localparam logic [PWM_BITS-1:0] MED_M  = PWM_BITS'(MEDIUM_DUTY);
    localparam logic [PWM_BITS-1:0] FAST_M = PWM_BITS'(FAST_DUTY);
    localparam logic [PWM_BITS-1:0] TURN_M = PWM_BITS'(TURN_DUTY);
    localparam logic [PWM_BITS-1:0] HARD_M = PWM_BITS'(HARD_DUTY);

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

    logic [PWM_BITS-1:0] tgt_mag_l, tgt_mag_r;
    logic                tgt_dir_l, tgt_dir_r;
    wheel_state_e        st_l, st_r;

    // Ramp prescaler: one-cycle tick every RAMP_DIV cycles; PWM counter free-runs.
    always_comb begin
        tick      = (presc_q == P_LAST);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_l_d   = (pwm_cnt_q < duty_l);
        pwm_r_d   = (pwm_cnt_q < duty_r);
    end

    // Prescaler, PWM counter and registered PWM outputs.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_l_q   <= pwm_l_d;
            pwm_r_q   <= pwm_r_d;
        end
    end

    // Drive command to signed per-wheel target (magnitude + direction, 1=forward).
    always_comb begin
        tgt_mag_l = '0;
        tgt_mag_r = '0;
        tgt_dir_l = 1'b1;
        tgt_dir_r = 1'b1;
        case (drive_state)
            DS_LEFT:     tgt_mag_r = TURN_M;
            DS_RIGHT:    tgt_mag_l = TURN_M;
            DS_SLOW: begin
                tgt_mag_l = SLOW_M;
                tgt_mag_r = SLOW_M;
            end
            DS_MEDIUM: begin
                tgt_mag_l = MED_M;
                tgt_mag_r = MED_M;
            end
            DS_FAST: begin
                tgt_mag_l = FAST_M;
                tgt_mag_r = FAST_M;
            end
            DS_REVERSE: begin
                tgt_mag_l = SLOW_M;
                tgt_mag_r = SLOW_M;
                tgt_dir_l = 1'b0;
                tgt_dir_r = 1'b0;
            end
            DS_LREVERSE: begin
                tgt_mag_r = TURN_M;
                tgt_dir_r = 1'b0;
            end
            DS_RREVERSE: begin
                tgt_mag_l = TURN_M;
                tgt_dir_l = 1'b0;
            end
            DS_HARD_L: begin
                tgt_mag_l = HARD_M;
                tgt_mag_r = HARD_M;
                tgt_dir_l = 1'b0;
            end
            DS_HARD_R: begin
                tgt_mag_l = HARD_M;
                tgt_mag_r = HARD_M;
                tgt_dir_r = 1'b0;
            end
            default: ;
        endcase
    end

    wheel_ramp #(
        .PWM_BITS    (PWM_BITS),
        .STEP        (STEP),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_wheel_l (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .tick       (tick),
        .mode_reset (mode_reset),
        .tgt_mag    (tgt_mag_l),
        .tgt_dir    (tgt_dir_l),
        .duty       (duty_l),
        .dir        (dir_l),
        .state      (st_l)
    );

    wheel_ramp #(
        .PWM_BITS    (PWM_BITS),
        .STEP        (STEP),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_wheel_r (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .tick       (tick),
        .mode_reset (mode_reset),
        .tgt_mag    (tgt_mag_r),
        .tgt_dir    (tgt_dir_r),
        .duty       (duty_r),
        .dir        (dir_r),
        .state      (st_r)
    );

    // Busy whenever either wheel is braking/dwelling or not yet at its target.
    always_comb begin
        busy = (st_l != WS_RUN) || (st_r != WS_RUN) ||
               (duty_l != tgt_mag_l) || (duty_r != tgt_mag_r);
    end

    assign pwm_l = pwm_l_q;
    assign pwm_r = pwm_r_q;

endmodule
